// File: rtl/line_drawer.sv
// line_drawer: integer Bresenham rasteriser (all octants) that streams pixel
// coordinates over a valid/ready link; off-screen points are stepped over silently.
module line_drawer #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
   parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [X_WIDTH-1:0] x1,
   input  logic [Y_WIDTH-1:0] y1,
   input  logic [X_WIDTH-1:0] x2,
   input  logic [Y_WIDTH-1:0] y2,
   input  logic               start,
   output logic               ready,
   output logic [X_WIDTH-1:0] pixel_x,
   output logic [Y_WIDTH-1:0] pixel_y,
   output logic               pixel_valid,
   input  logic               pixel_ready
);

   localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
   localparam logic [X_WIDTH:0]   X_LIM = HOR_ACTIVE_PIXELS[X_WIDTH:0];
   localparam logic [Y_WIDTH:0]   Y_LIM = VER_ACTIVE_PIXELS[Y_WIDTH:0];
   localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);
   localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, PLOT = 2'd2} state_t;

   state_t               state_r, state_s;
   logic                 ready_r, ready_s;
   logic                 pixel_valid_r, pixel_valid_s;
   logic [X_WIDTH-1:0]   pixel_x_r, pixel_x_s, x1_r, x1_s, x2_r, x2_s;
   logic [Y_WIDTH-1:0]   pixel_y_r, pixel_y_s, y1_r, y1_s, y2_r, y2_s;
   logic signed [W-1:0]  dx_r, dx_s, dy_r, dy_s, err_r, err_s;
   logic                 sx_neg_r, sx_neg_s, sy_neg_r, sy_neg_s;
   logic signed [W-1:0]  ddx_s, ddy_s, adx_s, ady_s;
   logic signed [W:0]    e2_s, dx_ext_s, dy_ext_s;
   logic                 advance_s, done_s;

   function automatic logic in_range(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
      return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
   endfunction

   assign ready       = ready_r;
   assign pixel_valid = pixel_valid_r;
   assign pixel_x     = pixel_x_r;
   assign pixel_y     = pixel_y_r;

   // Next-state and datapath update for the IDLE/INIT/PLOT controller
   always_comb begin
      state_s       = state_r;
      ready_s       = ready_r;
      pixel_valid_s = pixel_valid_r;
      pixel_x_s     = pixel_x_r;
      pixel_y_s     = pixel_y_r;
      x1_s          = x1_r;
      y1_s          = y1_r;
      x2_s          = x2_r;
      y2_s          = y2_r;
      dx_s          = dx_r;
      dy_s          = dy_r;
      err_s         = err_r;
      sx_neg_s      = sx_neg_r;
      sy_neg_s      = sy_neg_r;
      ddx_s         = $signed({{(W-X_WIDTH){1'b0}}, x2_r}) - $signed({{(W-X_WIDTH){1'b0}}, x1_r});
      ddy_s         = $signed({{(W-Y_WIDTH){1'b0}}, y2_r}) - $signed({{(W-Y_WIDTH){1'b0}}, y1_r});
      adx_s         = ddx_s[W-1] ? -ddx_s : ddx_s;
      ady_s         = ddy_s[W-1] ? -ddy_s : ddy_s;
      e2_s          = {err_r, 1'b0};
      dx_ext_s      = {dx_r[W-1], dx_r};
      dy_ext_s      = {dy_r[W-1], dy_r};
      // A suppressed (off-screen) point advances without waiting for the sink
      advance_s     = !pixel_valid_r || pixel_ready;
      done_s        = (pixel_x_r == x2_r) && (pixel_y_r == y2_r);
      case (state_r)
         IDLE: begin
            if (start && ready_r) begin
               x1_s    = x1;
               y1_s    = y1;
               x2_s    = x2;
               y2_s    = y2;
               ready_s = 1'b0;
               state_s = INIT;
            end else begin
               pixel_valid_s = 1'b0;
            end
         end
         INIT: begin
            dx_s          = adx_s;
            dy_s          = -ady_s;
            err_s         = adx_s - ady_s;
            sx_neg_s      = ddx_s[W-1];
            sy_neg_s      = ddy_s[W-1];
            pixel_x_s     = x1_r;
            pixel_y_s     = y1_r;
            pixel_valid_s = in_range(x1_r, y1_r);
            state_s       = PLOT;
         end
         PLOT: begin
            if (advance_s && done_s) begin
               pixel_valid_s = 1'b0;
               ready_s       = 1'b1;
               state_s       = IDLE;
            end else if (advance_s) begin
               // Both axis decisions use the pre-update e2
               if (e2_s >= dy_ext_s) begin
                  err_s     = err_s + dy_r;
                  pixel_x_s = sx_neg_r ? pixel_x_r - X_ONE : pixel_x_r + X_ONE;
               end else begin
                  pixel_x_s = pixel_x_r;
               end
               if (e2_s <= dx_ext_s) begin
                  err_s     = err_s + dx_r;
                  pixel_y_s = sy_neg_r ? pixel_y_r - Y_ONE : pixel_y_r + Y_ONE;
               end else begin
                  pixel_y_s = pixel_y_r;
               end
               pixel_valid_s = in_range(pixel_x_s, pixel_y_s);
            end else begin
               pixel_valid_s = pixel_valid_r;
            end
         end
         default: begin
            state_s       = IDLE;
            ready_s       = 1'b1;
            pixel_valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         ready_r       <= 1'b1;
         pixel_valid_r <= 1'b0;
         pixel_x_r     <= '0;
         pixel_y_r     <= '0;
         x1_r          <= '0;
         y1_r          <= '0;
         x2_r          <= '0;
         y2_r          <= '0;
         dx_r          <= '0;
         dy_r          <= '0;
         err_r         <= '0;
         sx_neg_r      <= 1'b0;
         sy_neg_r      <= 1'b0;
      end else begin
         state_r       <= state_s;
         ready_r       <= ready_s;
         pixel_valid_r <= pixel_valid_s;
         pixel_x_r     <= pixel_x_s;
         pixel_y_r     <= pixel_y_s;
         x1_r          <= x1_s;
         y1_r          <= y1_s;
         x2_r          <= x2_s;
         y2_r          <= y2_s;
         dx_r          <= dx_s;
         dy_r          <= dy_s;
         err_r         <= err_s;
         sx_neg_r      <= sx_neg_s;
         sy_neg_r      <= sy_neg_s;
      end
   end

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: hand-computed pixel sequences, ready latency,
// stalls, off-screen suppression, busy start and mid-line reset.
module tb_line_drawer;

   localparam int XW = 10;
   localparam int YW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic [XW-1:0] x1, x2, pixel_x;
   logic [YW-1:0] y1, y2, pixel_y;
   logic          start, ready, pixel_valid, pixel_ready;

   int checks = 0;
   int errors = 0;
   int exp_x[$];
   int exp_y[$];

   line_drawer #(.HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480)) dut (
      .clk(clk), .rst(rst), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .start(start),
      .ready(ready), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Draw one line; exp_c is the post-start edge after which ready is high again.
   task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                           input int exp_c, input int stall_idx, input int stall_len,
                           input bit busy_start);
      int  n      = 0;
      int  stalls = 0;
      bit  done   = 1'b0;
      @(negedge clk);
      check("idle_ready", ready, 1);
      x1 = ax1[XW-1:0]; y1 = ay1[YW-1:0]; x2 = ax2[XW-1:0]; y2 = ay2[YW-1:0];
      start = 1'b1;
      pixel_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("init_ready", ready, 0);
      check("init_valid", pixel_valid, 0);
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy_start && c == 3) begin
            start = 1'b1;
            x1 = 10'd9; y1 = 9'd9; x2 = 10'd1; y2 = 9'd1;
         end
         if (ready) begin
            check("ready_cycle", c, exp_c);
            check("pixel_count", n, exp_x.size());
            check("idle_valid", pixel_valid, 0);
            done = 1'b1;
         end else if (pixel_valid) begin
            if (n < exp_x.size()) begin
               check("pixel_x", pixel_x, exp_x[n]);
               check("pixel_y", pixel_y, exp_y[n]);
            end else begin
               check("extra_pixel", n, exp_x.size());
            end
            if (n == stall_idx && stalls < stall_len) begin
               pixel_ready = 1'b0;
               stalls++;
            end else begin
               pixel_ready = 1'b1;
               n++;
            end
         end else begin
            pixel_ready = 1'($urandom_range(0, 1));
         end
      end
      if (!done) check("timeout", 0, 1);
      start = 1'b0;
      pixel_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pixel_ready = 1'b1;
      x1 = '0; y1 = '0; x2 = '0; y2 = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_valid", pixel_valid, 0);
      check("rst_x", pixel_x, 0);
      check("rst_y", pixel_y, 0);
      rst = 1'b0;

      exp_x = '{0, 1, 2, 3};           exp_y = '{0, 0, 0, 0};
      run_line(0, 0, 3, 0, 5, -1, 0, 1'b0);

      exp_x = '{2, 2, 1, 1, 0, 0};     exp_y = '{5, 4, 3, 2, 1, 0};
      run_line(2, 5, 0, 0, 7, -1, 0, 1'b0);

      exp_x = '{7};                    exp_y = '{7};
      run_line(7, 7, 7, 7, 2, -1, 0, 1'b0);

      exp_x = '{0, 1, 2, 3, 4, 5};     exp_y = '{0, 0, 1, 1, 2, 2};
      run_line(0, 0, 5, 2, 10, 1, 3, 1'b0);

      exp_x = '{639};                  exp_y = '{10};
      run_line(639, 10, 640, 10, 3, -1, 0, 1'b0);

      exp_x = '{0, 1, 2, 3, 4, 5};     exp_y = '{0, 0, 1, 1, 2, 2};
      run_line(0, 0, 5, 2, 7, -1, 0, 1'b1);

      // Mid-line reset, then a fresh line must draw normally
      @(negedge clk);
      x1 = 10'd0; y1 = 9'd0; x2 = 10'd5; y2 = 9'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ready", ready, 1);
      check("mid_rst_valid", pixel_valid, 0);
      check("mid_rst_x", pixel_x, 0);
      check("mid_rst_y", pixel_y, 0);

      exp_x = '{3, 2, 1};              exp_y = '{1, 1, 1};
      run_line(3, 1, 1, 1, 4, -1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
